// File: rtl/mc_control_unit.sv
// Multicycle fetch/decode/execute/writeback sequencer feeding a combinational ALU.
// Holds an 8x32 register file (r0 reads zero) and the program counter.
module mc_control_unit #(
  parameter int PC_W   = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] alu_ip_0,
  output logic [DATA_W-1:0] alu_ip_1,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_op_0,
  input  logic              alu_change_pc,
  output logic [PC_W-1:0]   pc,
  output logic [2:0]        state,
  output logic              retired,
  input  logic [2:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  // state     | meaning
  // IDLE      | waiting for run
  // FETCH     | imem_req held until imem_ack, IR captured
  // DECODE    | operands read from the register file
  // EXECUTE   | ALU inputs valid, result and branch flag captured
  // WRITEBACK | register or pc update, retired pulse
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_BEQ = 3'b010;
  localparam logic [2:0] OP_BLT = 3'b011;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] aluout_q;
  logic              taken_q;
  logic [2:0]        alu_opcode_q;
  logic [DATA_W-1:0] rf_q [8];

  logic [2:0]        op, rd, rs1, rs2;
  logic [15:0]       imm16;
  logic [2:0]        ex_op;
  logic [PC_W-1:0]   br_off;
  logic              is_branch;
  logic              unused_ir;

  assign op        = ir_q[31:29];
  assign rd        = ir_q[28:26];
  assign rs1       = ir_q[25:23];
  assign rs2       = ir_q[22:20];
  assign imm16     = ir_q[15:0];
  assign unused_ir = ^ir_q[19:16];
  assign ex_op     = (op == OP_NOP || op == OP_LDI) ? 3'b000 : op;
  assign is_branch = (op == OP_BEQ) || (op == OP_BLT);
  assign br_off    = PC_W'($signed(imm16));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    retired  = 1'b0;
    case (state_q)
      S_IDLE:      if (run) state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = S_DECODE;
      end
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: begin
        retired = 1'b1;
        state_d = run ? S_FETCH : S_IDLE;
      end
      default:     state_d = S_IDLE;
    endcase
  end

  // ALU operand registers are A/B themselves, so they hold outside EXECUTE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= '0;
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      aluout_q     <= '0;
      taken_q      <= 1'b0;
      alu_opcode_q <= 3'b000;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      alu_opcode_q <= (state_d == S_EXECUTE) ? ex_op : 3'b000;
      case (state_q)
        S_FETCH: if (imem_ack) ir_q <= imem_rdata;
        S_DECODE: begin
          a_q <= rf_q[rs1];
          b_q <= rf_q[rs2];
        end
        S_EXECUTE: begin
          aluout_q <= alu_op_0;
          taken_q  <= alu_change_pc;
        end
        S_WRITEBACK: begin
          if (rd != 3'd0) begin
            if (op[2])            rf_q[rd] <= aluout_q;
            else if (op == OP_LDI) rf_q[rd] <= {{(DATA_W-16){1'b0}}, imm16};
          end
          if (is_branch && taken_q) pc_q <= pc_q + br_off;
          else                      pc_q <= pc_q + PC_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign state      = state_q;
  assign alu_ip_0   = a_q;
  assign alu_ip_1   = b_q;
  assign alu_opcode = alu_opcode_q;
  assign dbg_rdata  = rf_q[dbg_raddr];

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: behavioural ALU and instruction memory
// with programmable ack delay, immediate-assertion checks.
module tb_mc_control_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] alu_ip_0, alu_ip_1;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_op_0;
  logic        alu_change_pc;
  logic [15:0] pc;
  logic [2:0]  state;
  logic        retired;
  logic [2:0]  dbg_raddr = 3'd0;
  logic [31:0] dbg_rdata;

  logic [31:0] mem [32];
  int          ack_delay = 0;
  int          wcnt = 0;
  logic        ack_force = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc;
  int stable_err;
  logic [31:0] cap_ip0, cap_ip1;
  logic [2:0]  cap_opc;

  mc_control_unit #(.PC_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .alu_ip_0(alu_ip_0), .alu_ip_1(alu_ip_1), .alu_opcode(alu_opcode),
    .alu_op_0(alu_op_0), .alu_change_pc(alu_change_pc),
    .pc(pc), .state(state), .retired(retired),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  assign imem_ack   = (imem_req && (wcnt >= ack_delay)) || ack_force;
  assign imem_rdata = mem[imem_addr[4:0]];

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end

  always_comb begin
    alu_op_0      = 32'd0;
    alu_change_pc = 1'b0;
    case (alu_opcode)
      3'b010: alu_change_pc = (alu_ip_0 == alu_ip_1);
      3'b011: alu_change_pc = ($signed(alu_ip_0) < $signed(alu_ip_1));
      3'b100: alu_op_0 = alu_ip_0 + alu_ip_1;
      3'b101: alu_op_0 = alu_ip_0 - alu_ip_1;
      3'b110: alu_op_0 = alu_ip_0 & alu_ip_1;
      3'b111: alu_op_0 = alu_ip_0 | alu_ip_1;
      default: ;
    endcase
  end

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, 4'b0000, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    dbg_raddr = idx;
    #1;
    chk(tag, dbg_rdata, exp);
  endtask

  // Runs n instructions from IDLE and drops run in the last WRITEBACK.
  task automatic run_n(input int n);
    int r, guard;
    logic       in_fetch;
    logic [15:0] fa;
    r = 0; guard = 0; cyc = 0; stable_err = 0; in_fetch = 1'b0; fa = '0;
    run = 1'b1;
    while (r < n && guard < 300) begin
      @(negedge clk);
      guard++;
      if (state != 3'd0) cyc++;
      if (state == 3'd3) begin
        cap_ip0 = alu_ip_0; cap_ip1 = alu_ip_1; cap_opc = alu_opcode;
      end
      if (state == 3'd1) begin
        if (!in_fetch) begin fa = imem_addr; in_fetch = 1'b1; end
        if (imem_req !== 1'b1 || imem_addr !== fa) stable_err++;
      end else in_fetch = 1'b0;
      if (retired) begin
        r++;
        if (r == n) run = 1'b0;
      end
    end
    chk("run_timeout_retired", r, n);
    run = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;

    // reset and idle behaviour
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_state", state, 0);
    chk("idle_pc", pc, 0);
    chk("idle_req", imem_req, 0);
    chk("idle_opc", alu_opcode, 0);
    chk("idle_ip0", alu_ip_0, 0);
    for (int i = 0; i < 8; i++) chk_reg("reset_reg", 3'(i), 32'd0);
    ack_force = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_ack_state", state, 0);
    ack_force = 1'b0;

    // LDI / LDI / ADD
    mem[0] = enc(3'b001, 3'd1, 3'd0, 3'd0, 16'd2);
    mem[1] = enc(3'b001, 3'd2, 3'd0, 3'd0, 16'd3);
    mem[2] = enc(3'b100, 3'd3, 3'd1, 3'd2, 16'd0);
    run_n(3);
    chk("add_exec_opc", cap_opc, 3'b100);
    chk("add_exec_ip0", cap_ip0, 2);
    chk("add_exec_ip1", cap_ip1, 3);
    chk("add_r3", dbg_rdata, 32'hx === 0 ? 0 : dbg_rdata);
    chk_reg("add_r3_val", 3'd3, 5);
    chk("add_pc", pc, 3);
    chk("add_cycles", cyc, 12);
    chk("idle_retired", retired, 0);
    chk("opc_outside_exec", alu_opcode, 0);
    chk("ip0_hold", alu_ip_0, 2);
    chk("ip1_hold", alu_ip_1, 3);

    // SUB / AND / OR with r1=15, r2=3
    mem[3] = enc(3'b001, 3'd1, 3'd0, 3'd0, 16'd15);
    mem[4] = enc(3'b101, 3'd4, 3'd1, 3'd2, 16'd0);
    mem[5] = enc(3'b110, 3'd5, 3'd1, 3'd2, 16'd0);
    mem[6] = enc(3'b111, 3'd6, 3'd1, 3'd2, 16'd0);
    run_n(4);
    chk_reg("sub_r4", 3'd4, 12);
    chk_reg("and_r5", 3'd5, 3);
    chk_reg("or_r6", 3'd6, 15);
    chk("alu_pc", pc, 7);

    // reset between phases, then branches
    rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, 0);
    chk_reg("rst_r6", 3'd6, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem[0] = enc(3'b001, 3'd1, 3'd0, 3'd0, 16'd2);
    mem[1] = enc(3'b001, 3'd2, 3'd0, 3'd0, 16'd3);
    mem[2] = 32'd0;
    mem[3] = 32'd0;
    mem[4] = 32'd0;
    mem[5] = enc(3'b010, 3'd0, 3'd1, 3'd1, 16'hFFFE);
    run_n(6);
    chk("beq_back_pc", pc, 3);
    mem[3] = enc(3'b010, 3'd0, 3'd0, 3'd0, 16'd4);
    run_n(1);
    chk("beq_fwd_pc", pc, 7);
    mem[7] = enc(3'b011, 3'd0, 3'd1, 3'd2, 16'd4);
    run_n(1);
    chk("blt_taken_pc", pc, 11);
    mem[11] = enc(3'b011, 3'd0, 3'd2, 3'd1, 16'd4);
    run_n(1);
    chk("blt_not_taken_pc", pc, 12);

    // r0 writes discarded, pc wrap, zero-extended LDI
    mem[12] = enc(3'b100, 3'd0, 3'd1, 3'd2, 16'd0);
    mem[13] = enc(3'b001, 3'd0, 3'd0, 3'd0, 16'd7);
    run_n(2);
    chk_reg("r0_zero", 3'd0, 0);
    chk("r0_pc", pc, 14);
    mem[14] = enc(3'b010, 3'd0, 3'd0, 3'd0, 16'hFFF1);
    run_n(1);
    chk("branch_to_top_pc", pc, 16'hFFFF);
    mem[31] = 32'd0;
    run_n(1);
    chk("pc_wrap", pc, 0);
    mem[0] = enc(3'b001, 3'd7, 3'd0, 3'd0, 16'h8001);
    run_n(1);
    chk_reg("ldi_zext", 3'd7, 32'h0000_8001);

    // delayed ack
    ack_delay = 3;
    mem[1] = enc(3'b001, 3'd4, 3'd0, 3'd0, 16'd9);
    run_n(1);
    chk("wait_cycles", cyc, 7);
    chk("wait_fetch_stable", stable_err, 0);
    chk("wait_pc", pc, 2);
    chk_reg("wait_r4", 3'd4, 9);

    // reset during EXECUTE of ADD r3
    ack_delay = 0;
    mem[2] = enc(3'b100, 3'd3, 3'd1, 3'd2, 16'd0);
    run = 1'b1;
    guard = 0;
    while (state != 3'd3 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_execute", state, 3);
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    chk("abort_state", state, 0);
    chk("abort_pc", pc, 0);
    chk("abort_req", imem_req, 0);
    chk("abort_opc", alu_opcode, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_reg("abort_r3", 3'd3, 0);
    chk("abort_retired", retired, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle sequencer that sits directly upstream of the CPU's combinational ALU.
- Fetches a 32-bit instruction over a req/ack instruction-memory handshake and decodes it.
- Reads operands from an internal 8x32 register file and drives the ALU's ip_0/ip_1/opcode inputs.
- Consumes the ALU's op_0 and change_pc, writing back the result or updating the PC.
- A debug read port exposes the register file to the bench.

Parameters:
PC_W, 16, width of program counter and instruction address (word-addressed)
DATA_W, 32, datapath, register and instruction width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level enable; sampled only in IDLE and WRITEBACK
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= pc)
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  DATA_W  instruction word
alu_ip_0  out  DATA_W  ALU operand A (rs1 value)
alu_ip_1  out  DATA_W  ALU operand B (rs2 value)
alu_opcode  out  3  ALU opcode
alu_op_0  in  DATA_W  ALU result
alu_change_pc  in  1  ALU branch-taken flag
pc  out  PC_W  current program counter
state  out  3  FSM state (IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4)
retired  out  1  one-cycle pulse per completed instruction
dbg_raddr  in  3  debug register index
dbg_rdata  out  DATA_W  regfile[dbg_raddr], combinational; r0 reads 0

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - pc=0, state=IDLE, imem_req=0, retired=0.
  - IR=0, A=0, B=0, ALUOUT=0, TAKEN=0.
  - All 8 registers =0.
  - alu_opcode=000, alu_ip_0=alu_ip_1=0.
- Reset mid-instruction aborts it: no writeback, pc=0.
- Instruction format:
  - [31:29] op; [28:26] rd; [25:23] rs1; [22:20] rs2; [15:0] imm16.
  - op 000 NOP; 001 LDI (rd <= zero-extended imm16).
  - op 010 BEQ; 011 BLT (branch to pc + sign-extended imm16 if ALU asserts change_pc).
  - op 100 ADD, 101 SUB, 110 AND, 111 OR (rd <= rs1 op rs2).
- FSM:
  - IDLE: imem_req=0. run=1 -> FETCH.
  - FETCH: imem_req=1, imem_addr=pc, held until imem_ack.
    - On ack: IR<=imem_rdata, -> DECODE.
    - Ack-in-same-cycle-as-req is legal (zero wait).
    - imem_ack while imem_req=0 is ignored.
    - run is ignored in FETCH.
  - DECODE: A<=reg[rs1], B<=reg[rs2] (r0 always 0). -> EXECUTE.
  - EXECUTE:
    - alu_ip_0=A, alu_ip_1=B.
    - alu_opcode=IR.op for op 010-111; 000 for NOP/LDI.
    - ALUOUT<=alu_op_0, TAKEN<=alu_change_pc. -> WRITEBACK.
  - WRITEBACK:
    - op 1xx: reg[rd]<=ALUOUT. LDI: reg[rd]<={16'b0, imm16}.
    - Writes to rd=0 are discarded.
    - Branch op with TAKEN=1: pc<=pc+sext(imm16) mod 2^PC_W. Otherwise pc<=pc+1, wrapping 2^PC_W-1 -> 0.
    - retired=1 this cycle only.
    - run=1 -> FETCH, else -> IDLE.
- ALU output timing: alu_ip_0/alu_ip_1/alu_opcode are registered. They hold their EXECUTE values in other states except alu_opcode, which is 000 outside EXECUTE.
- Latency: 4 cycles per instruction with zero-wait ack, plus 1 cycle per ack wait cycle.
- Hazards: the next DECODE always follows the previous WRITEBACK, so back-to-back dependent instructions read the updated value. No forwarding is needed.
- Debug port has no side effects and may be read in any state.

Test Plan:
1. Reset hold 5 cycles, run=0 for 10 cycles -> state=0, pc=0, imem_req=0, dbg_rdata=0 for all indices.
2. Program LDI r1,2; LDI r2,3; ADD r3,r1,r2 with zero-wait ack, bench wiring the real ALU.
   - Required: in the ADD EXECUTE cycle, alu_opcode=100, alu_ip_0=2, alu_ip_1=3.
   - Required: r3=5, pc=3, exactly 3 retired pulses, 12 cycles from first FETCH.
3. With r1=15, r2=3, run SUB r4,r1,r2; AND r5,r1,r2; OR r6,r1,r2 -> r4=12, r5=3, r6=15.
4. Branches:
   - BEQ r1,r1,imm=0xFFFE at pc=5 -> pc=3.
   - BLT r1,r2 with r1=2, r2=3, imm=4 at pc=7 -> pc=11.
   - BLT r2,r1 (not taken) at pc=11 -> pc=12.
5. ADD r0,r1,r2 and LDI r0,7 -> dbg r0 reads 0. pc=0xFFFF NOP -> pc=0.
6. imem_ack delayed 3 cycles -> imem_req and imem_addr stable throughout, instruction takes 7 cycles. rst_n low during EXECUTE of ADD r3 -> r3 stays 0, pc=0, state=IDLE immediately.
